// File: rtl/io_pkg.sv
// Shared definitions for the IO input path: FSM state encoding and
// default debounce timing.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        VALID        = 2'd1,
        WAIT_RELEASE = 2'd2
    } io_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_CNT_W           = 18;

endpackage

// File: rtl/io_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and debounced
// level with one-cycle press/release pulses.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_stable,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_press;
    logic             r_release;

    // The counter only runs while the synchronised level disagrees with the
    // stable one, and is cleared on toggle, so it never passes LP_LIMIT.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LIMIT) begin
                r_cnt     <= '0;
                r_stable  <= ~r_stable;
                r_press   <= ~r_stable;
                r_release <= r_stable;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level         = r_sync2;
    assign o_stable        = r_stable;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;

endmodule

// File: rtl/io_input_ctrl.sv
// Feeds the IO stage: one debounced button press latches the switch bank into
// in_data and raises flagIn until the processor acknowledges the read.
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int SIGN_EXT        = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SW_W-1:0]   switches,
    input  logic              btn_enter,
    input  logic              read_ack,
    input  logic              stop,
    output logic [DATA_W-1:0] in_data,
    output logic              flagIn,
    output logic              waiting_led,
    output logic [1:0]        o_dbg_state
);

    logic              w_level;
    logic              w_stable;
    logic              w_press;
    logic              w_release;
    logic [SW_W-1:0]   r_sw_sync1;
    logic [SW_W-1:0]   r_sw_sync2;
    logic [DATA_W-1:0] w_sw_ext;
    logic [DATA_W-1:0] r_in_data;
    logic              r_led;
    logic [1:0]        r_warm;
    logic              r_armed;
    io_state_t         r_state;
    io_state_t         w_next_state;
    logic              w_capture;

    io_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_btn           (btn_enter),
        .o_level         (w_level),
        .o_stable        (w_stable),
        .o_press_pulse   (w_press),
        .o_release_pulse (w_release)
    );

    always_comb begin
        w_sw_ext             = '0;
        w_sw_ext[SW_W-1:0]   = r_sw_sync2;
        for (int i = SW_W; i < DATA_W; i++) begin
            w_sw_ext[i] = (SIGN_EXT != 0) ? r_sw_sync2[SW_W-1] : 1'b0;
        end
    end

    // A button still held through reset must be seen released before a press
    // counts, so the synchronised level is watched once the pipeline refills.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_warm  <= 2'd0;
            r_armed <= 1'b0;
        end else if (r_warm != 2'd2) begin
            r_warm <= r_warm + 2'd1;
        end else if (!w_level) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
            r_in_data  <= '0;
            r_led      <= 1'b0;
            r_state    <= IDLE;
        end else begin
            r_sw_sync1 <= switches;
            r_sw_sync2 <= r_sw_sync1;
            r_led      <= stop & ~flagIn;
            r_state    <= w_next_state;
            if (w_capture) begin
                r_in_data <= w_sw_ext;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press && r_armed) begin
                    w_capture    = 1'b1;
                    w_next_state = VALID;
                end
            end
            VALID: begin
                // Presses are ignored here, including one coinciding with ack.
                if (read_ack) begin
                    w_next_state = w_stable ? WAIT_RELEASE : IDLE;
                end
            end
            WAIT_RELEASE: begin
                if (w_release) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign in_data     = r_in_data;
    assign flagIn      = (r_state == VALID);
    assign waiting_led = r_led;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: a zero-extending and a sign-extending instance
// share all stimulus; expectations come from timing and extension rules.
module tb_io_input_ctrl;

    localparam int D       = 4;
    localparam int LAT     = D + 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_VAL  = 2'd1;
    localparam logic [1:0] S_WREL = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw = '0;
    logic        btn = 1'b0;
    logic        read_ack = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] in_data0, in_data1;
    logic        flag0, flag1, led0, led1;
    logic [1:0]  st0, st1;

    int n_cmp = 0;
    int n_err = 0;
    int rises = 0;
    logic last_flag = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clock = ~clock;

    io_input_ctrl #(.DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(D), .CNT_W(3), .SIGN_EXT(0)) dut_zx (
        .clock(clock), .reset(reset), .switches(sw), .btn_enter(btn), .read_ack(read_ack),
        .stop(stop), .in_data(in_data0), .flagIn(flag0), .waiting_led(led0), .o_dbg_state(st0));

    io_input_ctrl #(.DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(D), .CNT_W(3), .SIGN_EXT(1)) dut_sx (
        .clock(clock), .reset(reset), .switches(sw), .btn_enter(btn), .read_ack(read_ack),
        .stop(stop), .in_data(in_data1), .flagIn(flag1), .waiting_led(led1), .o_dbg_state(st1));

    function automatic logic [31:0] ext(input logic [15:0] v, input bit sx);
        return sx ? {{16{v[15]}}, v} : {16'h0000, v};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (flag0 === 1'b1 && last_flag !== 1'b1) rises++;
        last_flag = flag0;
    endtask

    task automatic wait_flag(output int n);
        n = 0;
        while (flag0 !== 1'b1 && n < 40) begin tick(); n++; end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (st0 !== S_IDLE && n < 40) begin tick(); n++; end
    endtask

    task automatic pulse_ack();
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
    endtask

    task automatic check_capture(input string name);
        logic [15:0] v;
        v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++;
        if (in_data0 !== ext(v, 0)) begin n_err++; $display("FAIL %s_zx: got %h expected %h", name, in_data0, ext(v, 0)); end
        n_cmp++;
        if (in_data1 !== ext(v, 1)) begin n_err++; $display("FAIL %s_sx: got %h expected %h", name, in_data1, ext(v, 1)); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if (flag0 !== 1'b0) begin n_err++; $display("FAIL reset_flag: got %b expected 0", flag0); end
        n_cmp++; if (in_data0 !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", in_data0); end
        n_cmp++; if (led0 !== 1'b0) begin n_err++; $display("FAIL reset_led: got %b expected 0", led0); end
        n_cmp++; if (st0 !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", st0, S_IDLE); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_clean_press();
        int n;
        sw = 16'h00A5; btn = 1'b1; exp_q.push_back(sw);
        wait_flag(n);
        n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL clean_latency: got %0d expected %0d", n, LAT); end
        check_capture("clean_data");
        repeat (12) tick();
        n_cmp++; if (flag0 !== 1'b1) begin n_err++; $display("FAIL clean_hold_flag: got %b expected 1", flag0); end
        pulse_ack();
        n_cmp++; if (flag0 !== 1'b0) begin n_err++; $display("FAIL clean_ack_flag: got %b expected 0", flag0); end
        n_cmp++; if (st0 !== S_WREL) begin n_err++; $display("FAIL clean_ack_state: got %0d expected %0d", st0, S_WREL); end
        n_cmp++; if (in_data0 !== 32'h000000A5) begin n_err++; $display("FAIL clean_data_kept: got %h expected 000000a5", in_data0); end
        btn = 1'b0;
        wait_idle(n);
        n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL clean_release: got %0d expected %0d", n, LAT); end
    endtask

    task automatic test_bounce();
        int n, r0;
        r0 = rises;
        sw = 16'h0C3C; exp_q.push_back(sw);
        btn = 1'b1; tick(); btn = 1'b0; tick(); btn = 1'b1; tick(); btn = 1'b0; tick(); btn = 1'b1;
        wait_flag(n);
        n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL bounce_latency: got %0d expected %0d", n, LAT); end
        check_capture("bounce_data");
        repeat (10) tick();
        n_cmp++; if (rises - r0 !== 1) begin n_err++; $display("FAIL bounce_captures: got %0d expected 1", rises - r0); end
        pulse_ack();
        btn = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_sign_ext();
        int n;
        sw = 16'h8001; btn = 1'b1; exp_q.push_back(sw);
        wait_flag(n);
        n_cmp++; if (in_data0 !== 32'h00008001) begin n_err++; $display("FAIL sext0_data: got %h expected 00008001", in_data0); end
        n_cmp++; if (in_data1 !== 32'hFFFF8001) begin n_err++; $display("FAIL sext1_data: got %h expected ffff8001", in_data1); end
        check_capture("sext_model");
        pulse_ack();
        btn = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_hold_valid();
        int n;
        sw = 16'h0003; btn = 1'b1; exp_q.push_back(sw);
        wait_flag(n);
        check_capture("hold_first");
        sw = 16'h0007; btn = 1'b0;
        repeat (12) tick();
        btn = 1'b1;
        repeat (12) tick();
        n_cmp++; if (in_data0 !== 32'h00000003) begin n_err++; $display("FAIL hold_data: got %h expected 00000003", in_data0); end
        n_cmp++; if (flag0 !== 1'b1) begin n_err++; $display("FAIL hold_flag: got %b expected 1", flag0); end
        pulse_ack();
        n_cmp++; if (st0 !== S_WREL) begin n_err++; $display("FAIL hold_ack_state: got %0d expected %0d", st0, S_WREL); end
        btn = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_ack_stall();
        int n, r0;
        stop = 1'b1;
        tick(); tick();
        n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL stall_led_on: got %b expected 1", led0); end
        sw = 16'h0011; btn = 1'b1; exp_q.push_back(sw);
        wait_flag(n);
        n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL stall_led_lag: got %b expected 1", led0); end
        tick();
        n_cmp++; if (led0 !== 1'b0) begin n_err++; $display("FAIL stall_led_off: got %b expected 0", led0); end
        check_capture("stall_data");
        btn = 1'b0;
        repeat (12) tick();
        r0 = rises;
        sw = 16'h0022; btn = 1'b1;
        repeat (D + 3) tick();
        pulse_ack();
        n_cmp++; if (flag0 !== 1'b0) begin n_err++; $display("FAIL ackpress_flag: got %b expected 0", flag0); end
        n_cmp++; if (st0 !== S_WREL) begin n_err++; $display("FAIL ackpress_state: got %0d expected %0d", st0, S_WREL); end
        repeat (12) tick();
        n_cmp++; if (rises !== r0) begin n_err++; $display("FAIL ackpress_captures: got %0d expected %0d", rises, r0); end
        n_cmp++; if (in_data0 !== 32'h00000011) begin n_err++; $display("FAIL ackpress_data: got %h expected 00000011", in_data0); end
        n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL stall_led_again: got %b expected 1", led0); end
        btn = 1'b0;
        wait_idle(n);
        stop = 1'b0;
    endtask

    task automatic test_ack_idle();
        pulse_ack();
        n_cmp++; if (st0 !== S_IDLE) begin n_err++; $display("FAIL idle_ack_state: got %0d expected %0d", st0, S_IDLE); end
        n_cmp++; if (flag0 !== 1'b0) begin n_err++; $display("FAIL idle_ack_flag: got %b expected 0", flag0); end
    endtask

    task automatic test_reset_mid();
        int n, r0;
        sw = 16'h0042; btn = 1'b1; exp_q.push_back(sw);
        wait_flag(n);
        check_capture("rstmid_data");
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (flag0 !== 1'b0) begin n_err++; $display("FAIL rstmid_flag: got %b expected 0", flag0); end
        n_cmp++; if (in_data0 !== 32'h0) begin n_err++; $display("FAIL rstmid_data_clr: got %h expected 0", in_data0); end
        r0 = rises;
        repeat (20) tick();
        n_cmp++; if (rises !== r0 || flag0 !== 1'b0) begin n_err++; $display("FAIL rstmid_held: got rises %0d flag %b expected %0d 0", rises, flag0, r0); end
        btn = 1'b0;
        repeat (10) tick();
        sw = 16'h0055; btn = 1'b1; exp_q.push_back(sw);
        wait_flag(n);
        n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL rstmid_repress: got %0d expected %0d", n, LAT); end
        check_capture("rstmid_new");
        pulse_ack();
        btn = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_random();
        int n, nb, tap;
        for (int it = 0; it < 10; it++) begin
            sw = 16'($urandom_range(0, 16'hFFFF));
            nb = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                btn = 1'b1; repeat ($urandom_range(1, D - 1)) tick();
                btn = 1'b0; repeat ($urandom_range(1, D - 1)) tick();
            end
            exp_q.push_back(sw);
            btn = 1'b1;
            wait_flag(n);
            n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, n, LAT); end
            check_capture("rnd_data");
            sw = 16'($urandom_range(0, 16'hFFFF));
            tap = $urandom_range(0, 1);
            if (tap != 0) begin
                btn = 1'b0;
                repeat (12) tick();
                pulse_ack();
                n_cmp++; if (st0 !== S_IDLE || flag0 !== 1'b0) begin n_err++; $display("FAIL rnd_tap[%0d]: got state %0d flag %b expected 0 0", it, st0, flag0); end
            end else begin
                repeat ($urandom_range(0, 5)) tick();
                pulse_ack();
                n_cmp++; if (st0 !== S_WREL || flag0 !== 1'b0) begin n_err++; $display("FAIL rnd_ack[%0d]: got state %0d flag %b expected 2 0", it, st0, flag0); end
                btn = 1'b0;
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    repeat ($urandom_range(1, D - 1)) tick();
                    btn = 1'b1; repeat ($urandom_range(1, D - 1)) tick();
                    btn = 1'b0;
                end
                wait_idle(n);
                n_cmp++; if (n !== LAT) begin n_err++; $display("FAIL rnd_release[%0d]: got %0d expected %0d", it, n, LAT); end
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sign_ext();
        test_hold_valid();
        test_ack_stall();
        test_ack_idle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
